// File: rtl/icache_fetch_unit.sv
// Direct-mapped instruction cache for the IF stage: 1-cycle hits, burst refill on miss,
// hold buffer for a frozen IF/ID register, and fence.i flush of all valid bits.
module icache_fetch_unit #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned LINES      = 16,
   parameter int unsigned LINE_WORDS = 4
) (
   input  logic                  i_Clk,
   input  logic                  i_Rst,
   input  logic [ADDR_WIDTH-1:0] i_Addr,
   input  logic                  i_RdEn,
   input  logic                  i_HoldOut,
   input  logic                  i_Flush,
   output logic [31:0]           o_Inst,
   output logic                  o_InstValid,
   output logic                  o_Stall,
   output logic                  o_MemReq,
   output logic [ADDR_WIDTH-1:0] o_MemAddr,
   input  logic                  i_MemAck,
   input  logic [31:0]           i_MemData
);

   localparam int unsigned OFF   = $clog2(LINE_WORDS);
   localparam int unsigned IDX   = $clog2(LINES);
   localparam int unsigned TAG_W = ADDR_WIDTH - IDX - OFF - 2;
   localparam logic [31:0] NOP   = 32'h0000_0013;
   localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'((1 << (OFF + 2)) - 1);

   typedef enum logic [1:0] {IDLE, REFILL, DONE} state_t;

   state_t state_q, state_d;

   logic [31:0]           data_mem [LINES*LINE_WORDS];
   logic [TAG_W-1:0]      tag_mem  [LINES];
   logic [LINES-1:0]      valid_q;

   logic [ADDR_WIDTH-1:0] base_q;
   logic [IDX-1:0]        idx_q;
   logic [TAG_W-1:0]      tag_q;
   logic [OFF-1:0]        cnt_q;
   logic                  flush_pend_q;

   logic                  hold_q;
   logic [31:0]           hold_buf_q;

   logic [OFF-1:0]        a_word_c;
   logic [IDX-1:0]        a_idx_c;
   logic [TAG_W-1:0]      a_tag_c;
   logic [ADDR_WIDTH-1:0] line_base_c;
   logic [OFF-1:0]        cnt_inc_c;
   logic [31:0]           rd_word_c;
   logic                  drain_c;
   logic                  lookup_c;
   logic                  hit_c;
   logic                  miss_c;
   logic                  last_ack_c;

   assign a_word_c    = i_Addr[OFF+1:2];
   assign a_idx_c     = i_Addr[IDX+OFF+1:OFF+2];
   assign a_tag_c     = i_Addr[ADDR_WIDTH-1:IDX+OFF+2];
   assign line_base_c = i_Addr & LINE_MASK;
   assign cnt_inc_c   = cnt_q + OFF'(1);
   assign rd_word_c   = data_mem[{a_idx_c, a_word_c}];
   assign drain_c     = hold_q && !i_HoldOut;

   // Lookup only in IDLE; a hold-buffer drain cycle does no array read
   always_comb begin
      state_d    = state_q;
      lookup_c   = 1'b0;
      hit_c      = 1'b0;
      miss_c     = 1'b0;
      last_ack_c = 1'b0;
      case (state_q)
         IDLE: begin
            lookup_c = i_RdEn && !drain_c;
            hit_c    = lookup_c && !i_Flush && valid_q[a_idx_c] && (tag_mem[a_idx_c] == a_tag_c);
            miss_c   = lookup_c && !hit_c;
            if (miss_c) state_d = REFILL;
         end
         REFILL: begin
            last_ack_c = i_MemAck && (cnt_q == OFF'(LINE_WORDS - 1));
            if (last_ack_c) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign o_Stall = !i_Rst && (miss_c || (state_q != IDLE));

   // Refill control, bus request and valid bits
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         state_q      <= IDLE;
         valid_q      <= '0;
         o_MemReq     <= 1'b0;
         o_MemAddr    <= '0;
         base_q       <= '0;
         idx_q        <= '0;
         tag_q        <= '0;
         cnt_q        <= '0;
         flush_pend_q <= 1'b0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (i_Flush)     valid_q          <= '0;
               else if (miss_c) valid_q[a_idx_c] <= 1'b0;
               if (miss_c) begin
                  o_MemReq     <= 1'b1;
                  o_MemAddr    <= line_base_c;
                  base_q       <= line_base_c;
                  idx_q        <= a_idx_c;
                  tag_q        <= a_tag_c;
                  cnt_q        <= '0;
                  flush_pend_q <= 1'b0;
               end
            end
            REFILL: begin
               if (i_Flush) flush_pend_q <= 1'b1;
               if (last_ack_c) begin
                  o_MemReq <= 1'b0;
               end else if (i_MemAck) begin
                  cnt_q     <= cnt_inc_c;
                  o_MemAddr <= base_q | ADDR_WIDTH'({cnt_inc_c, 2'b00});
               end
            end
            DONE: begin
               // A flush seen during the burst leaves the new line invalid too
               if (flush_pend_q || i_Flush) valid_q        <= '0;
               else                         valid_q[idx_q] <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Data and tag arrays carry no reset; the valid bits guard them
   always_ff @(posedge i_Clk) begin
      if (state_q == REFILL && i_MemAck) data_mem[{idx_q, cnt_q}] <= i_MemData;
      if (state_q == DONE)               tag_mem[idx_q]           <= tag_q;
   end

   // Instruction output and hold buffer; hold freezes the output, first parked hit wins
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         o_Inst      <= NOP;
         o_InstValid <= 1'b0;
         hold_q      <= 1'b0;
         hold_buf_q  <= NOP;
      end else if (i_HoldOut) begin
         if (hit_c && !hold_q) begin
            hold_buf_q <= rd_word_c;
            hold_q     <= 1'b1;
         end
      end else if (hold_q) begin
         o_Inst      <= hold_buf_q;
         o_InstValid <= 1'b1;
         hold_q      <= 1'b0;
      end else if (hit_c) begin
         o_Inst      <= rd_word_c;
         o_InstValid <= 1'b1;
      end else begin
         o_InstValid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_icache_fetch_unit.sv
// Directed bench for icache_fetch_unit: miss/refill, slow bus, hold, flush, reset abort, conflicts.
// Backing memory returns 0xA0000000 ^ address for every word.
module tb_icache_fetch_unit;

   logic        i_Clk;
   logic        i_Rst;
   logic [31:0] i_Addr;
   logic        i_RdEn;
   logic        i_HoldOut;
   logic        i_Flush;
   logic [31:0] o_Inst;
   logic        o_InstValid;
   logic        o_Stall;
   logic        o_MemReq;
   logic [31:0] o_MemAddr;
   logic        i_MemAck;
   logic [31:0] i_MemData;

   int errors = 0;
   int checks = 0;

   icache_fetch_unit #(
      .ADDR_WIDTH(32),
      .LINES(16),
      .LINE_WORDS(4)
   ) dut (
      .i_Clk(i_Clk),
      .i_Rst(i_Rst),
      .i_Addr(i_Addr),
      .i_RdEn(i_RdEn),
      .i_HoldOut(i_HoldOut),
      .i_Flush(i_Flush),
      .o_Inst(o_Inst),
      .o_InstValid(o_InstValid),
      .o_Stall(o_Stall),
      .o_MemReq(o_MemReq),
      .o_MemAddr(o_MemAddr),
      .i_MemAck(i_MemAck),
      .i_MemData(i_MemData)
   );

   initial begin
      i_Clk = 1'b0;
      forever #5 i_Clk = ~i_Clk;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'hA000_0000 ^ a;
   endfunction

   task automatic step();
      @(posedge i_Clk);
      #1;
   endtask

   // Serve a line refill; called in the miss cycle, returns one cycle into IDLE after DONE
   task automatic do_refill(input logic [31:0] base, input int gap, input bit flush_mid);
      int w;
      int wait_n;
      int cyc;
      bit flushed;
      logic [31:0] exp_addr;
      w = 0;
      wait_n = gap - 1;
      cyc = 0;
      flushed = 1'b0;
      step();
      while (w < 4 && cyc < 100) begin
         exp_addr = base + 32'(4 * w);
         checks++;
         if (o_MemReq !== 1'b1 || o_MemAddr !== exp_addr || o_Stall !== 1'b1) begin
            errors++;
            $display("FAIL refill_bus cyc=%0d got req=%b addr=%h stall=%b, want req=1 addr=%h stall=1",
                     cyc, o_MemReq, o_MemAddr, o_Stall, exp_addr);
         end
         if (flush_mid && w == 2 && !flushed) begin
            i_Flush = 1'b1;
            flushed = 1'b1;
         end
         if (wait_n == 0) begin
            i_MemAck  = 1'b1;
            i_MemData = mem_word(exp_addr);
            w++;
            wait_n = gap - 1;
         end else begin
            i_MemAck = 1'b0;
            wait_n--;
         end
         step();
         i_MemAck = 1'b0;
         i_Flush  = 1'b0;
         cyc++;
      end
      checks++;
      if (w != 4 || o_Stall !== 1'b1 || o_MemReq !== 1'b0) begin
         errors++;
         $display("FAIL refill_done got words=%0d stall=%b req=%b, want words=4 stall=1 req=0",
                  w, o_Stall, o_MemReq);
      end
      step();
   endtask

   task automatic test_reset();
      i_Rst = 1'b1;
      repeat (2) step();
      checks++;
      if (o_Inst !== 32'h0000_0013 || o_InstValid !== 1'b0) begin
         errors++;
         $display("FAIL reset_inst got inst=%h valid=%b, want inst=00000013 valid=0", o_Inst, o_InstValid);
      end
      checks++;
      if (o_Stall !== 1'b0 || o_MemReq !== 1'b0 || o_MemAddr !== 32'h0) begin
         errors++;
         $display("FAIL reset_bus got stall=%b req=%b addr=%h, want 0 0 00000000", o_Stall, o_MemReq, o_MemAddr);
      end
      i_Rst = 1'b0;
      step();
   endtask

   task automatic test_miss_refill();
      i_RdEn = 1'b1;
      i_Addr = 32'h100;
      #1;
      checks++;
      if (o_Stall !== 1'b1) begin
         errors++;
         $display("FAIL miss_stall got %b, want 1", o_Stall);
      end
      do_refill(32'h100, 1, 1'b0);
      i_Addr = 32'h104;
      #1;
      checks++;
      if (o_Stall !== 1'b0) begin
         errors++;
         $display("FAIL hit_stall got %b, want 0", o_Stall);
      end
      step();
      checks++;
      if (o_Inst !== 32'hA000_0104 || o_InstValid !== 1'b1) begin
         errors++;
         $display("FAIL hit_word1 got inst=%h valid=%b, want a0000104 1", o_Inst, o_InstValid);
      end
      i_Addr = 32'h10C;
      step();
      checks++;
      if (o_Inst !== 32'hA000_010C) begin
         errors++;
         $display("FAIL hit_last_word got %h, want a000010c", o_Inst);
      end
      i_RdEn = 1'b0;
      step();
      checks++;
      if (o_Inst !== 32'hA000_010C || o_InstValid !== 1'b0 || o_Stall !== 1'b0) begin
         errors++;
         $display("FAIL rden_low got inst=%h valid=%b stall=%b, want a000010c 0 0", o_Inst, o_InstValid, o_Stall);
      end
   endtask

   task automatic test_slow_bus();
      i_RdEn = 1'b1;
      i_Addr = 32'h180;
      #1;
      checks++;
      if (o_Stall !== 1'b1) begin
         errors++;
         $display("FAIL slow_miss_stall got %b, want 1", o_Stall);
      end
      do_refill(32'h180, 3, 1'b0);
      i_Addr = 32'h188;
      step();
      checks++;
      if (o_Inst !== 32'hA000_0188 || o_InstValid !== 1'b1) begin
         errors++;
         $display("FAIL slow_hit got inst=%h valid=%b, want a0000188 1", o_Inst, o_InstValid);
      end
   endtask

   task automatic test_hold();
      i_HoldOut = 1'b1;
      i_Addr    = 32'h100;
      for (int i = 0; i < 3; i++) begin
         step();
         i_Addr = 32'h104;
         checks++;
         if (o_Inst !== 32'hA000_0188 || o_InstValid !== 1'b1) begin
            errors++;
            $display("FAIL hold_frozen cycle=%0d got inst=%h valid=%b, want a0000188 1", i, o_Inst, o_InstValid);
         end
      end
      i_HoldOut = 1'b0;
      i_Addr    = 32'h108;
      #1;
      checks++;
      if (o_Stall !== 1'b0) begin
         errors++;
         $display("FAIL hold_drain_stall got %b, want 0", o_Stall);
      end
      step();
      checks++;
      if (o_Inst !== 32'hA000_0100 || o_InstValid !== 1'b1) begin
         errors++;
         $display("FAIL hold_release got inst=%h valid=%b, want a0000100 1", o_Inst, o_InstValid);
      end
      step();
      checks++;
      if (o_Inst !== 32'hA000_0108) begin
         errors++;
         $display("FAIL hold_after got %h, want a0000108", o_Inst);
      end
   endtask

   task automatic test_flush_refill();
      i_Addr = 32'h240;
      #1;
      checks++;
      if (o_Stall !== 1'b1) begin
         errors++;
         $display("FAIL flush_miss got %b, want 1", o_Stall);
      end
      do_refill(32'h240, 1, 1'b1);
      #1;
      checks++;
      if (o_Stall !== 1'b1) begin
         errors++;
         $display("FAIL flush_line_invalid got stall=%b, want 1", o_Stall);
      end
      i_Addr = 32'h100;
      #1;
      checks++;
      if (o_Stall !== 1'b1) begin
         errors++;
         $display("FAIL flush_all_invalid got stall=%b, want 1", o_Stall);
      end
   endtask

   // Continues the 0x100 miss left pending by test_flush_refill
   task automatic test_reset_mid_refill();
      for (int w = 0; w < 2; w++) begin
         step();
         checks++;
         if (o_MemAddr !== 32'h100 + 32'(4 * w) || o_MemReq !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre word=%0d got addr=%h req=%b, want %h 1", w, o_MemAddr, o_MemReq, 32'h100 + 32'(4 * w));
         end
         i_MemAck  = 1'b1;
         i_MemData = mem_word(32'h100 + 32'(4 * w));
      end
      step();
      i_MemAck = 1'b0;
      i_Rst    = 1'b1;
      #1;
      checks++;
      if (o_MemReq !== 1'b0 || o_Stall !== 1'b0 || o_MemAddr !== 32'h0) begin
         errors++;
         $display("FAIL abort_reset got req=%b stall=%b addr=%h, want 0 0 00000000", o_MemReq, o_Stall, o_MemAddr);
      end
      step();
      i_Rst = 1'b0;
      #1;
      checks++;
      if (o_Stall !== 1'b1) begin
         errors++;
         $display("FAIL abort_remiss got stall=%b, want 1", o_Stall);
      end
      do_refill(32'h100, 1, 1'b0);
   endtask

   // 0x140 is index 4 (no conflict with 0x100); 0x200 shares index 0 and evicts it
   task automatic test_conflict();
      i_Addr = 32'h100;
      #1;
      checks++;
      if (o_Stall !== 1'b0) begin
         errors++;
         $display("FAIL conf_hit0 got stall=%b, want 0", o_Stall);
      end
      step();
      checks++;
      if (o_Inst !== 32'hA000_0100) begin
         errors++;
         $display("FAIL conf_word0 got %h, want a0000100", o_Inst);
      end
      i_Addr = 32'h140;
      #1;
      checks++;
      if (o_Stall !== 1'b1) begin
         errors++;
         $display("FAIL conf_miss140 got stall=%b, want 1", o_Stall);
      end
      do_refill(32'h140, 1, 1'b0);
      i_Addr = 32'h100;
      #1;
      checks++;
      if (o_Stall !== 1'b0) begin
         errors++;
         $display("FAIL conf_keep100 got stall=%b, want 0", o_Stall);
      end
      step();
      i_Addr = 32'h200;
      #1;
      checks++;
      if (o_Stall !== 1'b1) begin
         errors++;
         $display("FAIL conf_miss200 got stall=%b, want 1", o_Stall);
      end
      do_refill(32'h200, 1, 1'b0);
      i_Addr = 32'h100;
      #1;
      checks++;
      if (o_Stall !== 1'b1) begin
         errors++;
         $display("FAIL conf_evicted got stall=%b, want 1", o_Stall);
      end
      i_RdEn = 1'b0;
      step();
      checks++;
      if (o_Stall !== 1'b0 || o_MemReq !== 1'b0) begin
         errors++;
         $display("FAIL conf_idle got stall=%b req=%b, want 0 0", o_Stall, o_MemReq);
      end
      i_RdEn  = 1'b1;
      i_Addr  = 32'h200;
      i_Flush = 1'b1;
      #1;
      checks++;
      if (o_Stall !== 1'b1) begin
         errors++;
         $display("FAIL flush_beats_hit got stall=%b, want 1", o_Stall);
      end
      i_RdEn = 1'b0;
      step();
      i_Flush = 1'b0;
      i_RdEn  = 1'b1;
      #1;
      checks++;
      if (o_Stall !== 1'b1) begin
         errors++;
         $display("FAIL idle_flush_cleared got stall=%b, want 1", o_Stall);
      end
      i_RdEn = 1'b0;
      step();
   endtask

   initial begin
      i_Rst     = 1'b1;
      i_Addr    = 32'h0;
      i_RdEn    = 1'b0;
      i_HoldOut = 1'b0;
      i_Flush   = 1'b0;
      i_MemAck  = 1'b0;
      i_MemData = 32'h0;
      test_reset();
      test_miss_refill();
      test_slow_bus();
      test_hold();
      test_flush_refill();
      test_reset_mid_refill();
      test_conflict();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
